// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional write-to-read forwarding is selected by REG_FILE_BYPASS_EN.
package reg_file_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_RD        = 2;
    localparam int DEF_ZERO_REG      = 1;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: address mux, x0 masking, optional forwarding, output flop.
// Latency 1 cycle; no backpressure. Forwarding enabled by REG_FILE_BYPASS_EN.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int ZERO_REG      = DEF_ZERO_REG
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             i_run,
    input  logic [ADDRESS_WIDTH-1:0]                         i_ra,
    input  logic [(2**ADDRESS_WIDTH)-1:0][WORD_WIDTH-1:0]    i_mem,
`ifdef REG_FILE_BYPASS_EN
    input  logic                                             i_wen,
    input  logic [ADDRESS_WIDTH-1:0]                         i_wa,
    input  logic [WORD_WIDTH-1:0]                            i_wd,
`endif
    output logic [WORD_WIDTH-1:0]                            o_rd
);

    logic [WORD_WIDTH-1:0] w_rd;
    logic [WORD_WIDTH-1:0] r_rd;

    always_comb begin
        w_rd = i_mem[i_ra];
`ifdef REG_FILE_BYPASS_EN
        // i_wen already excludes discarded (x0 / clear-collision) writes
        if (i_wen && (i_wa == i_ra)) begin
            w_rd = i_wd;
        end
`endif
        if ((ZERO_REG != 0) && (i_ra == '0)) begin
            w_rd = '0;
        end
        if (!i_run) begin
            w_rd = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else begin
            r_rd <= w_rd;
        end
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with self-zeroing INIT sweep and CLR request.
// Read latency 1 cycle; RDY low while the sweep runs. Forwarding via REG_FILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_RD        = DEF_NUM_RD,
    parameter int ZERO_REG      = DEF_ZERO_REG
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] RA,
    input  logic [ADDRESS_WIDTH-1:0]       WA,
    input  logic [WORD_WIDTH-1:0]          WD,
    input  logic                           WEN,
    input  logic                           CLR,
    output logic [NUM_RD*WORD_WIDTH-1:0]   RD,
    output logic                           RDY
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] CNT_END = (ADDRESS_WIDTH+1)'(DEPTH);

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [ADDRESS_WIDTH:0]               r_cnt;
    logic [ADDRESS_WIDTH:0]               w_cnt_nxt;
    logic                                 r_rdy;
    logic                                 w_sweep_we;
    logic                                 w_run;
    logic                                 w_wen;
    logic [DEPTH-1:0][WORD_WIDTH-1:0]     r_mem;

    assign w_run = (r_state == ST_RUN);
    assign w_wen = w_run && WEN && !CLR && !((ZERO_REG != 0) && (WA == '0));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            ST_INIT: begin
                // cnt runs one past the last address so RUN starts the cycle after the final write
                if (r_cnt == CNT_END) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_sweep_we = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (CLR) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= (w_state_nxt == ST_RUN);
        end
    end

    // Storage has no reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_cnt[ADDRESS_WIDTH-1:0]] <= '0;
        end else if (w_wen) begin
            r_mem[WA] <= WD;
        end
    end

    assign RDY = r_rdy;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        reg_file_read_port #(
            .WORD_WIDTH    (WORD_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .ZERO_REG      (ZERO_REG)
        ) u_rd (
            .clk   (clk),
            .rst_n (rst_n),
            .i_run (w_run),
            .i_ra  (RA[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .i_mem (r_mem),
`ifdef REG_FILE_BYPASS_EN
            .i_wen (w_wen),
            .i_wa  (WA),
            .i_wd  (WD),
`endif
            .o_rd  (RD[g*WORD_WIDTH +: WORD_WIDTH])
        );
    end

endmodule
